// File: rtl/uart_tx_fifo_seq.sv
// uart_tx_fifo_seq
// Byte FIFO feeding a UART transmitter, plus a small launch sequencer that
// pops one byte at a time, pulses uart_tx_start and tracks the UART busy
// handshake. It flags a sequencing error if busy never rises after a launch.

module uart_tx_fifo_seq #(
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = 4,
  parameter int BUSY_TMO = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        wr_data,
  input  logic              wr_en,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              seq_err,
  output logic [7:0]        uart_tx_data,
  output logic              uart_tx_start,
  input  logic              uart_tx_busy
);

  // Timer only needs to count 0..BUSY_TMO-1 while waiting for busy.
  localparam int TMO_W = (BUSY_TMO > 2) ? $clog2(BUSY_TMO) : 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          mem_q [DEPTH];
  logic [ADDR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]     count_q, count_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                overflow_q;
  logic                seq_err_q;
  logic [7:0]          data_q;
  logic                full_s, empty_s, wr_ok_s, pop_s, tmo_hit_s;

  // Flags come straight from the registered occupancy count.
  assign full_s  = (count_q == (ADDR_W+1)'(DEPTH));
  assign empty_s = (count_q == {(ADDR_W+1){1'b0}});
  // A write while full is dropped, regardless of a same-cycle pop.
  assign wr_ok_s = wr_en & ~full_s;

  assign full          = full_s;
  assign empty         = empty_s;
  assign count         = count_q;
  assign overflow      = overflow_q;
  assign seq_err       = seq_err_q;
  assign uart_tx_data  = data_q;
  assign uart_tx_start = (state_q == START);

  // Sequencer next-state: pop in IDLE, pulse in START, then follow busy.
  always_comb begin
    state_d   = state_q;
    tmo_d     = tmo_q;
    pop_s     = 1'b0;
    tmo_hit_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty_s && !uart_tx_busy) begin
          pop_s   = 1'b1;
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        tmo_d   = {TMO_W{1'b0}};
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (uart_tx_busy) begin
          state_d = WAIT_DONE;
        end else if (tmo_q == TMO_W'(BUSY_TMO - 1)) begin
          // The launched byte is abandoned; the UART never acknowledged it.
          tmo_hit_s = 1'b1;
          state_d   = IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      WAIT_DONE: begin
        if (!uart_tx_busy) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT_DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Occupancy: write and pop in the same cycle cancel out.
  always_comb begin
    count_d = count_q;
    case ({wr_ok_s, pop_s})
      2'b10:   count_d = count_q + (ADDR_W+1)'(1);
      2'b01:   count_d = count_q - (ADDR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state, pointers, launch data and sticky error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      tmo_q      <= {TMO_W{1'b0}};
      count_q    <= {(ADDR_W+1){1'b0}};
      wr_ptr_q   <= {ADDR_W{1'b0}};
      rd_ptr_q   <= {ADDR_W{1'b0}};
      data_q     <= 8'h00;
      overflow_q <= 1'b0;
      seq_err_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      count_q <= count_d;
      if (wr_ok_s) begin
        wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
        data_q   <= mem_q[rd_ptr_q];
      end
      if (wr_en && full_s) begin
        overflow_q <= 1'b1;
      end
      if (tmo_hit_s) begin
        seq_err_q <= 1'b1;
      end
    end
  end

  // Storage array; contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_seq.sv
// Self-checking bench for uart_tx_fifo_seq: a queue-based reference model,
// a per-cycle compare process, a simple UART busy responder, directed
// scenarios with literal expectations and a randomized traffic phase.

module tb_uart_tx_fifo_seq;

  localparam int DEPTH = 16;
  localparam int TMO   = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] wr_data;
  logic       wr_en;
  logic       full, empty, overflow, seq_err, uart_tx_start, uart_tx_busy;
  logic [4:0] count;
  logic [7:0] uart_tx_data;

  uart_tx_fifo_seq #(.DEPTH(DEPTH), .ADDR_W(4), .BUSY_TMO(TMO)) dut (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr_en(wr_en),
    .full(full), .empty(empty), .count(count), .overflow(overflow),
    .seq_err(seq_err), .uart_tx_data(uart_tx_data),
    .uart_tx_start(uart_tx_start), .uart_tx_busy(uart_tx_busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Queue of stored bytes; launcher phase: 0 ready, 1 launching (start high),
  // 2 awaiting busy (m_wait cycles so far), 3 UART transmitting.
  logic [7:0] mq[$];
  int         m_phase = 0;
  int         m_wait  = 0;
  logic       m_ovf   = 1'b0;
  logic       m_serr  = 1'b0;
  logic [7:0] m_data  = 8'h00;
  logic       m_can_wr;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_phase = 0; m_wait = 0; m_ovf = 1'b0; m_serr = 1'b0; m_data = 8'h00;
    end else begin
      m_can_wr = wr_en && (mq.size() < DEPTH);
      if (wr_en && mq.size() == DEPTH) m_ovf = 1'b1;
      case (m_phase)
        0: if (mq.size() != 0 && !uart_tx_busy) begin
             m_data  = mq.pop_front();
             m_phase = 1;
           end
        1: begin m_phase = 2; m_wait = 0; end
        2: if (uart_tx_busy) m_phase = 3;
           else begin
             m_wait++;
             if (m_wait == TMO) begin m_serr = 1'b1; m_phase = 0; end
           end
        3: if (!uart_tx_busy) m_phase = 0;
        default: m_phase = 0;
      endcase
      if (m_can_wr) mq.push_back(wr_data);
    end
  end

  // ---------------- per-cycle compare ----------------
  logic chk_en = 1'b0;
  always @(negedge clk) begin
    if (!rst && chk_en) begin
      chk("count",    32'(count),         32'(mq.size()));
      chk("empty",    32'(empty),         32'(mq.size() == 0));
      chk("full",     32'(full),          32'(mq.size() == DEPTH));
      chk("overflow", 32'(overflow),      32'(m_ovf));
      chk("seq_err",  32'(seq_err),       32'(m_serr));
      chk("start",    32'(uart_tx_start), 32'(m_phase == 1));
      chk("tx_data",  32'(uart_tx_data),  32'(m_data));
    end
  end

  // Observed launch stream, for literal ordering checks.
  logic [7:0] log_q[$];
  always @(negedge clk) begin
    if (!rst && uart_tx_start) log_q.push_back(uart_tx_data);
  end

  // ---------------- UART busy responder ----------------
  // umode 0: busy rises the cycle after start and holds; 1: stuck high; 2: never busy.
  int   umode    = 0;
  logic rand_hold = 1'b0;
  int   bcnt     = 0;
  logic bdel     = 1'b0;
  always @(negedge clk or posedge rst) begin
    if (rst) begin
      uart_tx_busy = 1'b0; bcnt = 0; bdel = 1'b0;
    end else if (umode == 1) begin
      uart_tx_busy = 1'b1; bcnt = 0; bdel = 1'b0;
    end else if (umode == 2) begin
      uart_tx_busy = 1'b0; bcnt = 0; bdel = 1'b0;
    end else begin
      if (bdel) begin
        uart_tx_busy = 1'b1;
        bcnt = rand_hold ? int'($urandom_range(1, 25)) : 20;
        bdel = 1'b0;
      end else if (bcnt > 0) begin
        bcnt--;
        uart_tx_busy = (bcnt != 0);
      end else begin
        uart_tx_busy = 1'b0;
      end
      if (uart_tx_start) bdel = 1'b1;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic put(input logic [7:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_data = d;
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      wr_en = 1'b0;
    end
  endtask

  // Wait until the model has nothing queued or in flight (bounded).
  task automatic wait_idle(input int bound, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      @(negedge clk);
      wr_en = 1'b0;
      if (m_phase == 0 && mq.size() == 0 && !uart_tx_busy) ok = 1'b1;
    end
    chk({name, "_idle_reached"}, 32'(ok), 32'd1);
  endtask

  int l0;
  int got;
  logic [7:0] exp_q[$];

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00;
    @(negedge clk); @(negedge clk);
    // Reset state, literal values
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full",  32'(full),  32'd0);
    chk("rst_start", 32'(uart_tx_start), 32'd0);
    chk("rst_data",  32'(uart_tx_data),  32'h00);
    rst = 1'b0;
    chk_en = 1'b1;
    idle_n(2);

    // Single byte latency: start in cycle 2 only
    put(8'hA5);
    @(negedge clk); wr_en = 1'b0;
    chk("single_c1_start", 32'(uart_tx_start), 32'd0);
    @(negedge clk);
    chk("single_c2_start", 32'(uart_tx_start), 32'd1);
    chk("single_c2_data",  32'(uart_tx_data),  32'hA5);
    chk("single_c2_empty", 32'(empty),         32'd1);
    @(negedge clk);
    chk("single_c3_start", 32'(uart_tx_start), 32'd0);
    wait_idle(100, "single");

    // Burst ordering 01..05
    l0 = log_q.size();
    for (int i = 1; i <= 5; i++) put(8'(i));
    wait_idle(400, "burst");
    chk("burst_n", 32'(log_q.size() - l0), 32'd5);
    for (int i = 0; i < 5 && l0 + i < log_q.size(); i++)
      chk("burst_data", 32'(log_q[l0+i]), 32'(i + 1));

    // Full / overflow with busy stuck
    umode = 1;
    idle_n(2);
    l0 = log_q.size();
    for (int i = 0; i < 17; i++) put(8'h40 + 8'(i));
    idle_n(1);
    chk("full_count",    32'(count),    32'd16);
    chk("full_full",     32'(full),     32'd1);
    chk("full_overflow", 32'(overflow), 32'd1);
    umode = 0;
    wait_idle(1000, "full_drain");
    chk("full_drain_n", 32'(log_q.size() - l0), 32'd16);
    for (int i = 0; i < 16 && l0 + i < log_q.size(); i++)
      chk("full_drain_data", 32'(log_q[l0+i]), 32'(8'h40 + 8'(i)));

    // Wrap and simultaneous write/pop
    umode = 1;
    idle_n(2);
    l0 = log_q.size();
    exp_q.delete();
    for (int i = 0; i < 16; i++) begin put(8'h80 + 8'(i)); exp_q.push_back(8'h80 + 8'(i)); end
    idle_n(1);
    umode = 0;
    got = 0;
    for (int i = 0; i < 600 && got == 0; i++) begin
      @(negedge clk);
      if (log_q.size() >= l0 + 10) got = 1;
    end
    chk("wrap_drain10", 32'(got), 32'd1);
    for (int i = 0; i < 8; i++) begin
      put(8'h90 + 8'(i)); exp_q.push_back(8'h90 + 8'(i));
      idle_n($urandom_range(0, 6));
    end
    wait_idle(1000, "wrap");
    chk("wrap_n", 32'(log_q.size() - l0), 32'd24);
    for (int i = 0; i < 24 && l0 + i < log_q.size(); i++)
      chk("wrap_data", 32'(log_q[l0+i]), 32'(exp_q[i]));

    // Timeout: UART never raises busy
    umode = 2;
    l0 = log_q.size();
    put(8'hC1); put(8'hC2);
    idle_n(30);
    chk("tmo_seq_err", 32'(seq_err), 32'd1);
    chk("tmo_starts",  32'(log_q.size() - l0), 32'd2);
    chk("tmo_empty",   32'(empty), 32'd1);
    umode = 0;
    wait_idle(100, "tmo");

    // Randomized traffic
    rand_hold = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      wr_en   = ($urandom_range(0, 99) < 25);
      wr_data = 8'($urandom);
      if (c % 150 == 149) begin
        case ($urandom_range(0, 4))
          3:       umode = 1;
          4:       umode = 2;
          default: umode = 0;
        endcase
      end
    end
    umode = 0;
    rand_hold = 1'b0;
    wait_idle(2000, "random");

    // Reset in WAIT_DONE with 3 bytes queued
    for (int i = 0; i < 4; i++) put(8'hE0 + 8'(i));
    idle_n(5);
    chk("rstmid_queued", 32'(count), 32'd3);
    chk("rstmid_busy",   32'(uart_tx_busy), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rstmid_count", 32'(count),         32'd0);
    chk("rstmid_empty", 32'(empty),         32'd1);
    chk("rstmid_full",  32'(full),          32'd0);
    chk("rstmid_ovf",   32'(overflow),      32'd0);
    chk("rstmid_serr",  32'(seq_err),       32'd0);
    chk("rstmid_data",  32'(uart_tx_data),  32'h00);
    chk("rstmid_start", 32'(uart_tx_start), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    l0 = log_q.size();
    idle_n(40);
    chk("rstmid_no_start", 32'(log_q.size() - l0), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
